// File: rtl/des_round_engine.sv
// Iterative DES data path: one Feistel round every two cycles, with each round key
// fetched from an external key generator as the round needs it.
module des_round_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] dataIn,
  input  logic        fKg,
  output logic        rd,
  output logic [4:0]  inRound,
  input  logic [47:0] key,
  output logic [63:0] dataOut,
  output logic        done,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  // Handshake: start is taken only while busy=0; rd is a one-cycle strobe with inRound,
  // and key must be valid through the cycle after it; done is a one-cycle strobe with dataOut.
  typedef enum logic [2:0] {IDLE = 3'd0, WAITKG = 3'd1, FETCH = 3'd2, ROUND = 3'd3, DONE = 3'd4} state_t;

  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                              12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                              22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // Each S-box is 64 nibbles in row-major order, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  state_t      state;
  logic [31:0] l_q, r_q;
  logic [4:0]  rnd;
  logic [63:0] ip_val, fp_val;
  logic [47:0] e_val, s_in;
  logic [31:0] s_out, f_out, l_next, r_next;

  assign s_in   = e_val ^ key;
  assign l_next = r_q;
  assign r_next = l_q ^ f_out;
  assign fsm_state = state;

  // DES numbers bits from 1 at the MSB, so table entry t maps to vector bit (width - t).
  for (genvar g = 0; g < 64; g++) begin : g_ipfp
    assign ip_val[63-g] = dataIn[64-IP_T[g]];
    assign fp_val[63-g] = {r_next, l_next}[64-FP_T[g]];
  end
  for (genvar g = 0; g < 48; g++) begin : g_e
    assign e_val[47-g] = r_q[32-E_T[g]];
  end
  for (genvar g = 0; g < 32; g++) begin : g_p
    assign f_out[31-g] = s_out[32-P_T[g]];
  end
  for (genvar g = 0; g < 8; g++) begin : g_sbox
    logic [5:0]   six;
    logic [255:0] shifted;
    assign six     = s_in[47-6*g -: 6];
    assign shifted = SBOX[g] << {six[5], six[0], six[4:1], 2'b00};
    assign s_out[31-4*g -: 4] = shifted[255:252];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rnd     <= '0;
      rd      <= 1'b0;
      inRound <= '0;
      dataOut <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rd   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            {l_q, r_q} <= ip_val;
            rnd        <= 5'd1;
            busy       <= 1'b1;
            state      <= WAITKG;
          end
        end
        WAITKG: begin
          if (fKg) begin
            rd      <= 1'b1;
            inRound <= rnd;
            state   <= FETCH;
          end
        end
        FETCH: state <= ROUND;
        ROUND: begin
          l_q <= l_next;
          r_q <= r_next;
          // No swap after the last round: the output block is R16 || L16.
          if (rnd == 5'd16) begin
            dataOut <= fp_val;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            rnd     <= rnd + 5'd1;
            rd      <= 1'b1;
            inRound <= rnd + 5'd1;
            state   <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
